// File: rtl/uart_rx_fifo_if.sv
// Read-side first-word-fall-through stream of the UART receive FIFO.
// master = FIFO (drives data/valid), slave = consumer (drives ready).
interface uart_rx_fifo_if;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;

  modport master (output rd_data, output rd_valid, input rd_ready);
  modport slave  (input rd_data, input rd_valid, output rd_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive byte buffer behind the UART RX controller: drains the holding register, FWFT read side,
// sticky status. Optional macro UART_RX_FIFO_THRESH_EN makes rx_irq a level-threshold interrupt.
//
// state    | meaning
// S_IDLE   | waiting for a held byte with room in the FIFO
// S_UNLOAD | byte written; Unload_data high for this one cycle
module uart_rx_fifo #(
  parameter int DEPTH     = 16,
  parameter int CNT_W     = $clog2(DEPTH) + 1,
  parameter int THRESHOLD = 8
) (
  input  logic             Clk,
  input  logic             Resetn,
  input  logic [7:0]       RX_data,
  input  logic             RX_empty,
  input  logic             RX_overrun,
  input  logic             RX_frame_error,
  output logic             Unload_data,
  input  logic             flush,
  input  logic             clear_flags,
  uart_rx_fifo_if.master   rd,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             overrun_sticky,
  output logic             frame_err_sticky,
  output logic             rx_irq
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic {S_IDLE, S_UNLOAD} state_t;

  state_t           state;
  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             valid;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] count_nxt;
  logic             irq_nxt;

  assign valid       = (count != '0);
  assign push        = (state == S_IDLE) && !RX_empty && !full;
  assign pop         = valid && rd.rd_ready;
  assign rd.rd_valid = valid;
  assign rd.rd_data  = valid ? mem[rd_ptr] : 8'h00;

  always_comb begin
    count_nxt = count;
    if (flush)
      count_nxt = '0;
    else if (push && !pop)
      count_nxt = count + 1'b1;
    else if (pop && !push)
      count_nxt = count - 1'b1;
  end

`ifdef UART_RX_FIFO_THRESH_EN
  assign irq_nxt = (count_nxt >= CNT_W'(THRESHOLD));
`else
  // THRESHOLD only matters for the threshold-interrupt build
  wire [31:0] unused_threshold = THRESHOLD;
  assign irq_nxt = (count_nxt != '0);
`endif

  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      state            <= S_IDLE;
      Unload_data      <= 1'b0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      full             <= 1'b0;
      rx_irq           <= 1'b0;
      overrun_sticky   <= 1'b0;
      frame_err_sticky <= 1'b0;
    end else begin
      // RX_empty is not looked at in S_UNLOAD: the controller updates it at the end of that cycle
      case (state)
        S_IDLE: begin
          Unload_data <= push;
          if (push)
            state <= S_UNLOAD;
        end
        S_UNLOAD: begin
          Unload_data <= 1'b0;
          state       <= S_IDLE;
        end
        default: begin
          Unload_data <= 1'b0;
          state       <= S_IDLE;
        end
      endcase

      // flush drops a same-cycle push, yet the byte is still unloaded from the controller
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + 1'b1;
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
      end

      count  <= count_nxt;
      full   <= (count_nxt == CNT_W'(DEPTH));
      rx_irq <= irq_nxt;

      if (RX_overrun)
        overrun_sticky <= 1'b1;
      else if (clear_flags)
        overrun_sticky <= 1'b0;

      if (RX_frame_error)
        frame_err_sticky <= 1'b1;
      else if (clear_flags)
        frame_err_sticky <= 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Resetn && push && !flush)
      mem[wr_ptr] <= RX_data;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based reference model plus a behavioural
// model of the receive controller's holding register.
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int TH    = 4;

  logic             clk;
  logic             Resetn;
  logic [7:0]       RX_data;
  logic             RX_empty;
  logic             RX_overrun;
  logic             RX_frame_error;
  logic             Unload_data;
  logic             flush;
  logic             clear_flags;
  logic             rd_ready;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             overrun_sticky;
  logic             frame_err_sticky;
  logic             rx_irq;

  uart_rx_fifo_if rdi ();
  assign rdi.rd_ready = rd_ready;

  uart_rx_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W), .THRESHOLD(TH)) dut (
    .Clk(clk), .Resetn(Resetn), .RX_data(RX_data), .RX_empty(RX_empty),
    .RX_overrun(RX_overrun), .RX_frame_error(RX_frame_error), .Unload_data(Unload_data),
    .flush(flush), .clear_flags(clear_flags), .rd(rdi), .count(count), .full(full),
    .overrun_sticky(overrun_sticky), .frame_err_sticky(frame_err_sticky), .rx_irq(rx_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [7:0] q[$];
  logic [7:0] src_q[$];
  logic [7:0] popped_q[$];
  bit ctrl_hold, busy, ov_m, fe_m;
  bit follow_push, flush_on_push;
  int arrive_pct;
  int n_checks, n_pass;

  function automatic bit irq_exp(int n);
`ifdef UART_RX_FIFO_THRESH_EN
    return n >= TH;
`else
    return n != 0;
`endif
  endfunction

  // one clock cycle: compare outputs to the model, advance across the edge, update model + controller
  task automatic step();
    bit push_p, pop_p, was_busy;
    n_checks++;
    if (count !== CNT_W'(q.size())) $display("FAIL count: got %0d expected %0d", count, q.size());
    else n_pass++;
    n_checks++;
    if (rdi.rd_valid !== (q.size() != 0)) $display("FAIL rd_valid: got %b expected %b", rdi.rd_valid, q.size() != 0);
    else n_pass++;
    if (q.size() != 0) begin
      n_checks++;
      if (rdi.rd_data !== q[0]) $display("FAIL rd_data: got %02h expected %02h", rdi.rd_data, q[0]);
      else n_pass++;
    end
    n_checks++;
    if (full !== (q.size() == DEPTH)) $display("FAIL full: got %b expected %b", full, q.size() == DEPTH);
    else n_pass++;
    n_checks++;
    if (Unload_data !== busy) $display("FAIL unload: got %b expected %b", Unload_data, busy);
    else n_pass++;
    n_checks++;
    if (overrun_sticky !== ov_m || frame_err_sticky !== fe_m)
      $display("FAIL sticky: got ov=%b fe=%b expected ov=%b fe=%b", overrun_sticky, frame_err_sticky, ov_m, fe_m);
    else n_pass++;
    n_checks++;
    if (rx_irq !== irq_exp(q.size())) $display("FAIL rx_irq: got %b expected %b", rx_irq, irq_exp(q.size()));
    else n_pass++;

    push_p = Resetn && ctrl_hold && !busy && (q.size() != DEPTH);
    if (follow_push) rd_ready = push_p;
    if (flush_on_push) flush = push_p;
    pop_p = Resetn && rd_ready && (q.size() != 0);

    @(posedge clk); #1;

    was_busy = busy;
    if (!Resetn) begin
      q.delete(); busy = 0; ov_m = 0; fe_m = 0;
    end else begin
      if (flush) q.delete();
      else begin
        if (pop_p) popped_q.push_back(q.pop_front());
        if (push_p) q.push_back(RX_data);
      end
      busy = push_p;
      if (RX_overrun) ov_m = 1; else if (clear_flags) ov_m = 0;
      if (RX_frame_error) fe_m = 1; else if (clear_flags) fe_m = 0;
    end
    if (was_busy) ctrl_hold = 0;
    if (!ctrl_hold && src_q.size() != 0 && $urandom_range(99) < arrive_pct) begin
      RX_data = src_q.pop_front();
      ctrl_hold = 1;
    end
    RX_empty = !ctrl_hold;
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    while ((src_q.size() != 0 || ctrl_hold || busy) && n < budget) begin step(); n++; end
    n_checks++;
    if (src_q.size() != 0 || ctrl_hold || busy) $display("FAIL wait_idle: timeout after %0d cycles, %0d bytes pending", n, src_q.size());
    else n_pass++;
  endtask

  task automatic drain();
    int n = 0;
    rd_ready = 1;
    while (q.size() != 0 && n < 64) begin step(); n++; end
    rd_ready = 0;
    step();
    n_checks++;
    if (count !== '0) $display("FAIL drain: count got %0d expected 0", count);
    else n_pass++;
  endtask

  task automatic test_reset();
    Resetn = 0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (Unload_data !== 0 || count !== '0 || full !== 0 || rdi.rd_valid !== 0 || rdi.rd_data !== 8'h00 ||
        overrun_sticky !== 0 || frame_err_sticky !== 0 || rx_irq !== 0)
      $display("FAIL reset: got unload=%b count=%0d full=%b valid=%b data=%02h ov=%b fe=%b irq=%b expected all 0",
               Unload_data, count, full, rdi.rd_valid, rdi.rd_data, overrun_sticky, frame_err_sticky, rx_irq);
    else n_pass++;
    Resetn = 1;
  endtask

  task automatic test_single();
    src_q.push_back(8'h5A);
    step();
    step();
    n_checks++;
    if (Unload_data !== 1 || rdi.rd_valid !== 1 || rdi.rd_data !== 8'h5A || count !== CNT_W'(1))
      $display("FAIL single_capture: got unload=%b valid=%b data=%02h count=%0d expected 1 1 5a 1",
               Unload_data, rdi.rd_valid, rdi.rd_data, count);
    else n_pass++;
    step();
    n_checks++;
    if (Unload_data !== 0) $display("FAIL single_pulse: unload got %b expected 0", Unload_data);
    else n_pass++;
    rd_ready = 1;
    step();
    rd_ready = 0;
    n_checks++;
    if (count !== '0 || rdi.rd_valid !== 0) $display("FAIL single_pop: count got %0d expected 0", count);
    else n_pass++;
  endtask

  task automatic test_full();
    bit seen = 0;
    for (int i = 0; i < 16; i++) src_q.push_back(8'(i));
    wait_idle(100);
    n_checks++;
    if (full !== 1 || count !== CNT_W'(16)) $display("FAIL full_level: got full=%b count=%0d expected 1 16", full, count);
    else n_pass++;
    src_q.push_back(8'h10);
    for (int i = 0; i < 6; i++) begin step(); if (Unload_data) seen = 1; end
    n_checks++;
    if (seen) $display("FAIL full_hold: unload got 1 expected 0 while full");
    else n_pass++;
    rd_ready = 1;
    step();
    rd_ready = 0;
    seen = 0;
    for (int i = 0; i < 2; i++) begin step(); if (Unload_data) seen = 1; end
    n_checks++;
    if (!seen || count !== CNT_W'(16)) $display("FAIL full_refill: got unload_seen=%b count=%0d expected 1 16", seen, count);
    else n_pass++;
    wait_idle(10);
    for (int i = 1; i <= 16; i++) begin
      n_checks++;
      if (rdi.rd_data !== 8'(i)) $display("FAIL full_order: got %02h expected %02h", rdi.rd_data, 8'(i));
      else n_pass++;
      rd_ready = 1;
      step();
    end
    rd_ready = 0;
    step();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_l[$];
    int n = 0;
    bit bad = 0;
    popped_q.delete();
    for (int i = 0; i < 3; i++) begin exp_l.push_back(8'($urandom)); src_q.push_back(exp_l[i]); end
    wait_idle(20);
    popped_q.delete();
    for (int i = 0; i < 100; i++) begin exp_l.push_back(8'($urandom)); src_q.push_back(exp_l[3+i]); end
    follow_push = 1;
    while ((src_q.size() != 0 || ctrl_hold || busy) && n < 400) begin
      step();
      n++;
      if (count !== CNT_W'(3)) bad = 1;
    end
    follow_push = 0;
    rd_ready = 0;
    n_checks++;
    if (bad) $display("FAIL b2b_level: count left 3 during steady push/pop");
    else n_pass++;
    n_checks++;
    if (popped_q.size() != 100) $display("FAIL b2b_popcount: got %0d expected 100", popped_q.size());
    else n_pass++;
    bad = 0;
    for (int i = 0; i < popped_q.size() && i < 100; i++) if (popped_q[i] !== exp_l[i]) bad = 1;
    n_checks++;
    if (bad) $display("FAIL b2b_order: got corrupted byte sequence expected in-order bytes");
    else n_pass++;
    drain();
  endtask

  task automatic test_flush();
    bit seen = 0, leak = 0;
    for (int i = 0; i < 5; i++) src_q.push_back(8'(8'h20 + i));
    wait_idle(30);
    src_q.push_back(8'hAA);
    flush_on_push = 1;
    for (int i = 0; i < 10 && !seen; i++) begin step(); if (Unload_data) seen = 1; end
    flush_on_push = 0;
    flush = 0;
    n_checks++;
    if (!seen || count !== '0 || rdi.rd_valid !== 0)
      $display("FAIL flush_push: got unload_seen=%b count=%0d valid=%b expected 1 0 0", seen, count, rdi.rd_valid);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin step(); if (rdi.rd_valid || rdi.rd_data == 8'hAA) leak = 1; end
    n_checks++;
    if (leak) $display("FAIL flush_drop: got dropped byte aa visible expected never");
    else n_pass++;
  endtask

  task automatic test_flags();
    RX_overrun = 1; RX_frame_error = 1;
    step();
    RX_overrun = 0; RX_frame_error = 0;
    n_checks++;
    if (overrun_sticky !== 1 || frame_err_sticky !== 1)
      $display("FAIL flags_set: got ov=%b fe=%b expected 1 1", overrun_sticky, frame_err_sticky);
    else n_pass++;
    clear_flags = 1; RX_frame_error = 1;
    step();
    clear_flags = 0; RX_frame_error = 0;
    n_checks++;
    if (overrun_sticky !== 0 || frame_err_sticky !== 1)
      $display("FAIL flags_setwins: got ov=%b fe=%b expected 0 1", overrun_sticky, frame_err_sticky);
    else n_pass++;
    flush = 1;
    step();
    flush = 0;
    n_checks++;
    if (frame_err_sticky !== 1) $display("FAIL flags_flush: fe got %b expected 1", frame_err_sticky);
    else n_pass++;
    clear_flags = 1;
    step();
    clear_flags = 0;
    n_checks++;
    if (overrun_sticky !== 0 || frame_err_sticky !== 0)
      $display("FAIL flags_clear: got ov=%b fe=%b expected 0 0", overrun_sticky, frame_err_sticky);
    else n_pass++;
  endtask

  task automatic test_irq();
    for (int i = 1; i <= 5; i++) begin
      src_q.push_back(8'(8'h40 + i));
      wait_idle(10);
      n_checks++;
      if (rx_irq !== irq_exp(i)) $display("FAIL irq_fill%0d: got %b expected %b", i, rx_irq, irq_exp(i));
      else n_pass++;
    end
    for (int i = 4; i >= 0; i--) begin
      rd_ready = 1;
      step();
      rd_ready = 0;
      n_checks++;
      if (rx_irq !== irq_exp(i)) $display("FAIL irq_pop%0d: got %b expected %b", i, rx_irq, irq_exp(i));
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    src_q.push_back(8'h33);
    step();
    step();
    Resetn = 0;
    step();
    n_checks++;
    if (Unload_data !== 0 || count !== '0) $display("FAIL rst_unload: got unload=%b count=%0d expected 0 0", Unload_data, count);
    else n_pass++;
    src_q.push_back(8'h44);
    step();
    step();
    n_checks++;
    if (count !== '0) $display("FAIL rst_hold: count got %0d expected 0", count);
    else n_pass++;
    Resetn = 1;
    step();
    n_checks++;
    if (count !== CNT_W'(1) || rdi.rd_data !== 8'h44)
      $display("FAIL rst_recapture: got count=%0d data=%02h expected 1 44", count, rdi.rd_data);
    else n_pass++;
    drain();
  endtask

  task automatic test_random();
    arrive_pct = 60;
    for (int c = 0; c < 800; c++) begin
      if (src_q.size() < 4) src_q.push_back(8'($urandom));
      rd_ready       = ($urandom_range(2) != 0);
      flush          = ($urandom_range(59) == 0);
      RX_overrun     = ($urandom_range(29) == 0);
      RX_frame_error = ($urandom_range(29) == 0);
      clear_flags    = ($urandom_range(19) == 0);
      step();
    end
    flush = 0; RX_overrun = 0; RX_frame_error = 0; clear_flags = 0;
    arrive_pct = 100;
    rd_ready = 1;
    wait_idle(200);
    drain();
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    Resetn = 0; RX_data = 8'h00; RX_empty = 1; RX_overrun = 0; RX_frame_error = 0;
    flush = 0; clear_flags = 0; rd_ready = 0;
    ctrl_hold = 0; busy = 0; ov_m = 0; fe_m = 0;
    follow_push = 0; flush_on_push = 0; arrive_pct = 100;
    test_reset();
    test_single();
    test_full();
    test_back_to_back();
    test_flush();
    test_flags();
    test_irq();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
